// File: rtl/sprite_plotter.sv
// Sprite redraw engine: on an accepted start it erases the previous sprite
// rectangle, draws the new one, and writes one clipped pixel per clock.
module sprite_plotter #(
  parameter int          SPR_W     = 4,
  parameter int          SPR_H     = 4,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [DXW-1:0] LAST_DX = DXW'(SPR_W - 1);
  localparam logic [DYW-1:0] LAST_DY = DYW'(SPR_H - 1);
  localparam logic [8:0]     LIM_X   = 9'(SCREEN_W);
  localparam logic [7:0]     LIM_Y   = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [DXW-1:0] r_dx;
  logic [DYW-1:0] r_dy;
  logic [7:0]     r_old_x;
  logic [6:0]     r_old_y;
  logic           r_old_valid;
  logic [7:0]     r_new_x;
  logic [6:0]     r_new_y;
  logic [2:0]     r_colour;

  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic       w_on_screen;
  logic       w_last_col;
  logic       w_last_row;

  assign w_last_col = (r_dx == LAST_DX);
  assign w_last_row = (r_dy == LAST_DY);

  // Sums are one bit wider than the coordinate so off-screen pixels clip
  // instead of wrapping back to the left/top edge.
  assign w_base_x    = (r_state == ERASE) ? r_old_x : r_new_x;
  assign w_base_y    = (r_state == ERASE) ? r_old_y : r_new_y;
  assign w_sum_x     = {1'b0, w_base_x} + 9'(r_dx);
  assign w_sum_y     = {1'b0, w_base_y} + 8'(r_dy);
  assign w_on_screen = (w_sum_x < LIM_X) && (w_sum_y < LIM_Y);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dx        <= '0;
      r_dy        <= '0;
      r_old_x     <= '0;
      r_old_y     <= '0;
      r_old_valid <= 1'b0;
      r_new_x     <= '0;
      r_new_y     <= '0;
      r_colour    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_new_x  <= x_in;
            r_new_y  <= y_in;
            r_colour <= colour_in;
            r_dx     <= '0;
            r_dy     <= '0;
            r_state  <= r_old_valid ? ERASE : DRAW;
          end
        end
        ERASE, DRAW: begin
          if (w_last_col) begin
            r_dx <= '0;
            if (w_last_row) begin
              r_dy    <= '0;
              r_state <= (r_state == ERASE) ? DRAW : DONE;
            end else begin
              r_dy <= r_dy + 1'b1;
            end
          end else begin
            r_dx <= r_dx + 1'b1;
          end
        end
        DONE: begin
          r_old_x     <= r_new_x;
          r_old_y     <= r_new_y;
          r_old_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    plot        = 1'b0;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    if (r_state == ERASE || r_state == DRAW) begin
      plot_x      = w_sum_x[7:0];
      plot_y      = w_sum_y[6:0];
      plot_colour = (r_state == ERASE) ? BG_COLOUR : r_colour;
      plot        = w_on_screen;
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected per-cycle pixels are queued
// when a redraw is requested and compared as the DUT steps through it.
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot, busy, done;

  logic       s_start;
  logic [7:0] s_x_in;
  logic [6:0] s_y_in;
  logic [2:0] s_colour_in;
  logic [7:0] s_plot_x;
  logic [6:0] s_plot_y;
  logic [2:0] s_plot_colour;
  logic       s_plot, s_busy, s_done;

  always #5 clk = ~clk;

  sprite_plotter #(.SPR_W(4), .SPR_H(4), .SCREEN_W(160), .SCREEN_H(120),
                   .BG_COLOUR(3'b000)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot), .busy(busy), .done(done)
  );

  sprite_plotter #(.SPR_W(1), .SPR_H(1), .SCREEN_W(160), .SCREEN_H(120),
                   .BG_COLOUR(3'b000)) dut_1x1 (
    .clk(clk), .reset(reset), .start(s_start), .x_in(s_x_in), .y_in(s_y_in),
    .colour_in(s_colour_in), .plot_x(s_plot_x), .plot_y(s_plot_y),
    .plot_colour(s_plot_colour), .plot(s_plot), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic       p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_old_x;
  logic [6:0] m_old_y;
  logic       m_old_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pass(input int bx, input int by, input logic [2:0] col);
    pix_t e;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        e.p = ((bx + dx) < 160) && ((by + dy) < 120);
        e.x = 8'(bx + dx);
        e.y = 7'(by + dy);
        e.c = col;
        q.push_back(e);
      end
    end
  endtask

  // abort_at >= 0 asserts reset that many pixel cycles into the redraw.
  task automatic redraw(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input bit hammer, input int abort_at);
    pix_t e;
    int   n;
    q.delete();
    if (m_old_valid) push_pass(int'(m_old_x), int'(m_old_y), 3'b000);
    push_pass(int'(x), int'(y), c);
    n = q.size();
    @(negedge clk);
    start = 1'b1; x_in = x; y_in = y; colour_in = c;
    @(negedge clk);
    if (!hammer) start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        m_old_valid = 1'b0;
        q.delete();
        return;
      end
      e = q.pop_front();
      check("busy", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      check("plot", 32'(plot), 32'(e.p));
      if (e.p) begin
        check("plot_x", 32'(plot_x), 32'(e.x));
        check("plot_y", 32'(plot_y), 32'(e.y));
        check("colour", 32'(plot_colour), 32'(e.c));
      end
      @(negedge clk);
      if (hammer) x_in = x_in ^ 8'h5A;
    end
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_plot", 32'(plot), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_plot", 32'(plot), 32'd0);
    @(negedge clk);
    check("stay_idle", 32'(busy), 32'd0);
    m_old_x = x; m_old_y = y; m_old_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; colour_in = '0;
    s_start = 1'b0; s_x_in = '0; s_y_in = '0; s_colour_in = '0;
    m_old_x = '0; m_old_y = '0; m_old_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_xyc", {13'd0, plot_x, plot_y, plot_colour}, 32'd0);

    redraw(8'd10, 7'd20, 3'b100, 1'b0, -1);   // first draw, no erase
    redraw(8'd12, 7'd20, 3'b010, 1'b0, -1);   // erase + draw
    redraw(8'd12, 7'd20, 3'b110, 1'b0, -1);   // same position still erased
    redraw(8'd50, 7'd60, 3'b001, 1'b1, -1);   // start hammered, x_in toggled
    redraw(8'd30, 7'd40, 3'b101, 1'b0, 21);   // reset five cycles into DRAW
    check("post_rst_xyc", {13'd0, plot_x, plot_y, plot_colour}, 32'd0);
    redraw(8'd158, 7'd118, 3'b111, 1'b0, -1); // no erase, clipped corner
    redraw(8'd255, 7'd127, 3'b011, 1'b0, -1); // erase clipped, draw all clipped
    redraw(8'd0, 7'd0, 3'b001, 1'b0, -1);

    @(negedge clk);
    s_start = 1'b1; s_x_in = 8'd0; s_y_in = 7'd0; s_colour_in = 3'b011;
    @(negedge clk);
    s_start = 1'b0;
    check("s1_plot", 32'(s_plot), 32'd1);
    check("s1_xyc", {13'd0, s_plot_x, s_plot_y, s_plot_colour}, {13'd0, 8'd0, 7'd0, 3'b011});
    check("s1_busy", 32'(s_busy), 32'd1);
    @(negedge clk);
    check("s1_done", 32'(s_done), 32'd1);
    check("s1_done_plot", 32'(s_plot), 32'd0);
    @(negedge clk);
    check("s1_idle", 32'({s_busy, s_done}), 32'd0);
    s_start = 1'b1; s_x_in = 8'd159; s_y_in = 7'd119; s_colour_in = 3'b101;
    @(negedge clk);
    s_start = 1'b0;
    check("s2_erase", {12'd0, s_plot, s_plot_x, s_plot_y, s_plot_colour},
          {12'd0, 1'b1, 8'd0, 7'd0, 3'b000});
    @(negedge clk);
    check("s2_draw", {12'd0, s_plot, s_plot_x, s_plot_y, s_plot_colour},
          {12'd0, 1'b1, 8'd159, 7'd119, 3'b101});
    @(negedge clk);
    check("s2_done", 32'(s_done), 32'd1);
    @(negedge clk);
    check("s2_idle", 32'({s_busy, s_done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
